// File: rtl/memory_arbiter.sv
// Arbiter that shares one memory between an instruction-fetch read port and a data read/write port.
// One access is in flight at a time. Each access is followed by one RELEASE cycle. Ties alternate round-robin.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        dp_valid,
  input  logic        dp_write,
  input  logic [31:0] dp_addr,
  input  logic [31:0] dp_wdata,
  output logic        dp_done,
  output logic [31:0] dp_rdata,
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_data,
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  output logic [31:0] mem_out_addr,
  output logic        mem_out_valid,
  input  logic [31:0] mem_out_data,
  input  logic        mem_out_ready,
  input  logic        mem_addr_error,
  output logic        err_timeout,
  output logic        err_addr,
  output logic        err_port
);

  typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, RELEASE} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_grant;   // 0 = fetch, 1 = data
  logic [15:0] r_wait_cnt;
  logic        r_addr_err_d;
  logic        r_if_done;
  logic        r_dp_done;
  logic [31:0] r_if_data;
  logic [31:0] r_dp_rdata;
  logic [31:0] r_mem_in_addr;
  logic [31:0] r_mem_in_data;
  logic        r_mem_in_valid;
  logic [31:0] r_mem_out_addr;
  logic        r_mem_out_valid;
  logic        r_err_timeout;
  logic        r_err_addr;
  logic        r_err_port;

  logic        w_grant_if;
  logic        w_grant_dp;
  logic        w_busy;
  logic        w_ready;
  logic        w_owner;
  logic        w_timeout;
  logic        w_finish;
  logic        w_addr_err_rise;
  logic [15:0] w_cnt_next;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    w_state_next = r_state;
    w_grant_if   = 1'b0;
    w_grant_dp   = 1'b0;
    w_busy       = 1'b0;
    w_ready      = 1'b0;
    w_owner      = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_valid && dp_valid) begin
          w_grant_if = r_last_grant;
          w_grant_dp = !r_last_grant;
        end else begin
          w_grant_if = if_valid;
          w_grant_dp = dp_valid;
        end
        if (w_grant_if)      w_state_next = FETCH;
        else if (w_grant_dp) w_state_next = dp_write ? DWRITE : DREAD;
      end
      FETCH: begin
        w_busy  = 1'b1;
        w_ready = mem_out_ready;
      end
      DREAD: begin
        w_busy  = 1'b1;
        w_ready = mem_out_ready;
        w_owner = 1'b1;
      end
      DWRITE: begin
        w_busy  = 1'b1;
        w_ready = mem_in_ready;
        w_owner = 1'b1;
      end
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    w_cnt_next      = r_wait_cnt + 16'd1;
    // A ready seen in the same cycle as the limit still counts as a normal completion.
    w_timeout       = w_busy && !w_ready && (w_cnt_next >= TIMEOUT_LIMIT);
    w_finish        = w_busy && (w_ready || w_timeout);
    w_addr_err_rise = w_busy && mem_addr_error && !r_addr_err_d;
    if (w_finish) w_state_next = RELEASE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant    <= 1'b0;
      r_wait_cnt      <= '0;
      r_addr_err_d    <= 1'b0;
      r_if_done       <= 1'b0;
      r_dp_done       <= 1'b0;
      r_if_data       <= '0;
      r_dp_rdata      <= '0;
      r_mem_in_addr   <= '0;
      r_mem_in_data   <= '0;
      r_mem_in_valid  <= 1'b0;
      r_mem_out_addr  <= '0;
      r_mem_out_valid <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_err_addr      <= 1'b0;
      r_err_port      <= 1'b0;
    end else begin
      r_if_done    <= 1'b0;
      r_dp_done    <= 1'b0;
      r_addr_err_d <= mem_addr_error;

      if (w_grant_if) begin
        r_last_grant    <= 1'b0;
        r_wait_cnt      <= '0;
        r_mem_out_valid <= 1'b1;
        r_mem_out_addr  <= if_addr;
      end
      if (w_grant_dp) begin
        r_last_grant <= 1'b1;
        r_wait_cnt   <= '0;
        if (dp_write) begin
          r_mem_in_valid <= 1'b1;
          r_mem_in_addr  <= dp_addr;
          r_mem_in_data  <= dp_wdata;
        end else begin
          r_mem_out_valid <= 1'b1;
          r_mem_out_addr  <= dp_addr;
        end
      end

      if (w_busy) r_wait_cnt <= w_cnt_next;

      if (w_finish) begin
        r_mem_in_valid  <= 1'b0;
        r_mem_out_valid <= 1'b0;
        if (w_owner) r_dp_done <= 1'b1;
        else         r_if_done <= 1'b1;
        if (r_state == FETCH)       r_if_data  <= w_timeout ? 32'd0 : mem_out_data;
        else if (r_state == DREAD)  r_dp_rdata <= w_timeout ? 32'd0 : mem_out_data;
        else if (w_timeout)         r_dp_rdata <= 32'd0;
      end

      if (w_timeout)       r_err_timeout <= 1'b1;
      if (w_addr_err_rise) r_err_addr    <= 1'b1;
      // The port is recorded only for the first error of either kind.
      if ((w_timeout || w_addr_err_rise) && !r_err_timeout && !r_err_addr)
        r_err_port <= w_owner;
    end
  end

  assign if_done       = r_if_done;
  assign if_data       = r_if_data;
  assign dp_done       = r_dp_done;
  assign dp_rdata      = r_dp_rdata;
  assign mem_in_addr   = r_mem_in_addr;
  assign mem_in_data   = r_mem_in_data;
  assign mem_in_valid  = r_mem_in_valid;
  assign mem_out_addr  = r_mem_out_addr;
  assign mem_out_valid = r_mem_out_valid;
  assign err_timeout   = r_err_timeout;
  assign err_addr      = r_err_addr;
  assign err_port      = r_err_port;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles a memory access may wait for ready before abort; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all logic SHALL be on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge clk resets the block).
REQ-004 if_valid/if_addr  input  1/32  instruction-fetch read request, held until if_done.
REQ-005 if_done/if_data  output  1/32  one-cycle completion pulse; read data valid while if_done==1.
REQ-006 dp_valid/dp_write/dp_addr/dp_wdata  input  1/1/32/32  data-port request (dp_write=1 write), held until dp_done.
REQ-007 dp_done/dp_rdata  output  1/32  one-cycle completion pulse; dp_rdata valid on reads while dp_done==1.
REQ-008 mem_in_addr/mem_in_data/mem_in_valid  output  32/32/1  write channel to the shared memory.
REQ-009 mem_in_ready  input  1  memory write-complete indication.
REQ-010 mem_out_addr/mem_out_valid  output  32/1  read channel to the shared memory.
REQ-011 mem_out_data/mem_out_ready  input  32/1  memory read data and read-complete indication.
REQ-012 mem_addr_error  input  1  sticky address error from the memory.
REQ-013 err_timeout/err_addr/err_port  output  1/1/1  sticky timeout, sticky address error, port of first error (0=fetch, 1=data).

Function
REQ-014 All outputs SHALL be registered; the state machine SHALL have states IDLE, FETCH, DREAD, DWRITE, RELEASE.
REQ-015 In IDLE with exactly one requester valid, the block SHALL grant it; with both valid, it SHALL grant the port not granted last (round-robin; last_grant resets to fetch, so data wins first tie).
REQ-016 On a grant, the next cycle SHALL enter FETCH/DREAD/DWRITE with the matching mem_*_valid=1 and address (and mem_in_data=dp_wdata for writes) captured from the requester.
REQ-017 mem_in_valid and mem_out_valid SHALL never be 1 in the same cycle, and SHALL be 0 in IDLE and RELEASE.
REQ-018 Address/data to memory SHALL stay constant while the corresponding valid is 1.
REQ-019 When the relevant mem ready is sampled 1 in FETCH/DREAD/DWRITE, the next cycle SHALL have valid=0, the owning *_done=1, read data captured from mem_out_data, and state RELEASE.
REQ-020 RELEASE SHALL last exactly one cycle (memory returns to inactive), then IDLE; a back-to-back request is granted in that IDLE cycle at the earliest.
REQ-021 Request-to-done latency SHALL be 1 + N + 1 cycles, where N is the cycles mem valid is held until ready is sampled.
REQ-022 A 16-bit wait counter SHALL clear on grant and increment each busy cycle; if it reaches TIMEOUT_CYCLES without ready, the block SHALL deassert valid, pulse the owner's *_done with data 0, set err_timeout, and enter RELEASE.
REQ-023 mem_addr_error rising while busy SHALL set err_addr; err_port SHALL record the owner only for the first error of either kind.
REQ-024 Requests deasserted before *_done are illegal; the block SHALL complete the accepted access regardless and discard nothing.
REQ-025 *_done SHALL never be 1 for both ports in one cycle, nor for a port without a prior grant.

Reset
REQ-026 On reset==0: state IDLE, all valids/dones 0, addresses/data/if_data/dp_rdata 0, counter 0, last_grant=fetch, all err_* 0.
REQ-027 Reset mid-access SHALL abort immediately with no *_done pulse; valids SHALL be 0 in the first cycle after reset.

Verification
REQ-028 Fetch read 0x100, memory read ready after 3 cycles, data 0xDEADBEEF -> if_done one cycle with if_data=0xDEADBEEF, latency 5 cycles.
REQ-029 Data write 0x200 value 0x12345678, write ready after 1 cycle -> mem_in_valid 1 cycle, dp_done 3 cycles after dp_valid, mem_out_valid never 1.
REQ-030 Both ports request continuously from reset -> grants alternate data, fetch, data, fetch; RELEASE cycle with both valids 0 between each.
REQ-031 TIMEOUT_CYCLES=4, memory never ready -> valid held 4 cycles, dp_done with dp_rdata=0, err_timeout=1, err_port=1.
REQ-032 mem_addr_error pulses during fetch of 0x00A00000 -> err_addr=1, err_port=0, stays 1 until reset.
REQ-033 reset=0 during DREAD -> next cycle all valids 0, no dp_done, state IDLE.
